serial_subtractor: RTL

Bit-serial unsigned subtractor computing D = A − B − Bin over WIDTH clock cycles, one bit per cycle, LSB first, through a single one-bit full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's one-bit full-adder blocks in the arithmetic examples. It trades throughput for area and exposes a start/busy/done handshake so a testbench or controller can sequence operations.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: sequencing states
// and the helper that sizes the bit counter.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must represent 0..width, so it needs clog2(width+1) bits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when the bit underflows.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, D = A - B - Bin over WIDTH cycles, LSB first,
// with a start/busy/done handshake and back-to-back restart from DONE.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bout)
  );

  // Sequencer and datapath; DONE accepts a new start exactly like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr   <= A;
            r_b_sr   <= B;
            r_borrow <= Bin;
            r_d      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          // New bit enters at the MSB so the LSB lands in place last.
          r_d      <= (r_d >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign D    = r_d;
  assign Bout = r_borrow;
  assign busy = r_busy;
  assign done = r_done;

endmodule
